// File: rtl/cal_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cal_pkg : shared widths, month codes, FSM states and calendar helpers.
// Rev 1.0
// ---------------------------------------------------------------------------
package cal_pkg;

  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int YEAR_W  = $clog2(3000);

  localparam logic [MONTH_W-1:0] JAN = 4'd1;
  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MAR = 4'd3;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] MAY = 4'd5;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] JUL = 4'd7;
  localparam logic [MONTH_W-1:0] AUG = 4'd8;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] OCT = 4'd10;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    APPLY = 2'd2
  } fsm_state_t;

  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    return ((year % 12'd400) == '0) ||
           ((year[1:0] == 2'b00) && ((year % 12'd100) != '0));
  endfunction

  // Out-of-range month codes fall into the 31-day default; validation rejects them.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic [YEAR_W-1:0]  year);
    case (month)
      FEB:                return is_leap(year) ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV: return 5'd30;
      default:            return 5'd31;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cal_days_in_month.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cal_days_in_month : combinational month-length lookup for a month/year pair.
// Rev 1.0
// ---------------------------------------------------------------------------
module cal_days_in_month
  import cal_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   days
);

  assign days = days_in_month(month, year);

endmodule
`default_nettype wire

// File: rtl/cal_date_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cal_date_cnt : year/month/day counter with day-tick advance and checked
// user writes. Optional weekday tracking when CAL_WEEKDAY_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
module cal_date_cnt
  import cal_pkg::*;
#(
  parameter int          YEAR_W    = $clog2(3000),
  parameter int unsigned MIN_YEAR  = 2000,
  parameter int unsigned MAX_YEAR  = 2999,
  parameter int unsigned RST_YEAR  = 2000,
  parameter int unsigned RST_MONTH = 1,
`ifdef CAL_WEEKDAY_EN
  parameter int unsigned RST_WEEKDAY = 5,
`endif
  parameter int unsigned RST_DAY   = 1
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              day_tick_i,
  input  logic              set_valid_i,
  output logic              set_ready_o,
  input  logic [YEAR_W-1:0] set_year_i,
  input  logic [3:0]        set_month_i,
  input  logic [4:0]        set_day_i,
  output logic              set_err_o,
  output logic [YEAR_W-1:0] year_o,
  output logic [3:0]        month_o,
  output logic [4:0]        day_o,
`ifdef CAL_WEEKDAY_EN
  input  logic [2:0]        set_weekday_i,
  output logic [2:0]        weekday_o,
`endif
  output logic              date_upd_o
);

  localparam logic [YEAR_W-1:0]  c_min_year  = YEAR_W'(MIN_YEAR);
  localparam logic [YEAR_W-1:0]  c_max_year  = YEAR_W'(MAX_YEAR);
  localparam logic [YEAR_W-1:0]  c_rst_year  = YEAR_W'(RST_YEAR);
  localparam logic [MONTH_W-1:0] c_rst_month = MONTH_W'(RST_MONTH);
  localparam logic [DAY_W-1:0]   c_rst_day   = DAY_W'(RST_DAY);

  fsm_state_t         r_state;
  logic               r_ready;
  logic               r_upd;
  logic [YEAR_W-1:0]  r_year,  r_cap_year;
  logic [MONTH_W-1:0] r_month, r_cap_month;
  logic [DAY_W-1:0]   r_day,   r_cap_day;
  logic [DAY_W-1:0]   w_cur_dim, w_cap_dim;
  logic               w_accept;
  logic               w_wday_ok;
  logic               w_cap_ok;

  cal_days_in_month u_cur_dim (.month(r_month),     .year(r_year),     .days(w_cur_dim));
  cal_days_in_month u_cap_dim (.month(r_cap_month), .year(r_cap_year), .days(w_cap_dim));

`ifdef CAL_WEEKDAY_EN
  localparam logic [2:0] c_rst_wday = 3'(RST_WEEKDAY);
  logic [2:0] r_wday, r_cap_wday;
  assign w_wday_ok = (r_cap_wday <= 3'd6);
  assign weekday_o = r_wday;
`else
  assign w_wday_ok = 1'b1;
`endif

  assign w_accept = set_valid_i & r_ready;
  assign w_cap_ok = (r_cap_year >= c_min_year) && (r_cap_year <= c_max_year) &&
                    (r_cap_month >= JAN) && (r_cap_month <= DEC) &&
                    (r_cap_day != '0) && (r_cap_day <= w_cap_dim) && w_wday_ok;

  // Reject pulse is decoded from CHECK and the captured registers so it lands
  // one cycle after the handshake; it never depends on live inputs.
  assign set_err_o   = (r_state == CHECK) && !w_cap_ok;
  assign set_ready_o = r_ready;
  assign date_upd_o  = r_upd;
  assign year_o      = r_year;
  assign month_o     = r_month;
  assign day_o       = r_day;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_upd       <= 1'b0;
      r_year      <= c_rst_year;
      r_month     <= c_rst_month;
      r_day       <= c_rst_day;
      r_cap_year  <= '0;
      r_cap_month <= '0;
      r_cap_day   <= '0;
`ifdef CAL_WEEKDAY_EN
      r_wday      <= c_rst_wday;
      r_cap_wday  <= '0;
`endif
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cap_year  <= set_year_i;
            r_cap_month <= set_month_i;
            r_cap_day   <= set_day_i;
`ifdef CAL_WEEKDAY_EN
            r_cap_wday  <= set_weekday_i;
`endif
            r_ready     <= 1'b0;
            r_state     <= CHECK;
          end else if (day_tick_i) begin
            r_upd <= 1'b1;
`ifdef CAL_WEEKDAY_EN
            r_wday <= (r_wday >= 3'd6) ? 3'd0 : r_wday + 3'd1;
`endif
            if (r_day < w_cur_dim) begin
              r_day <= r_day + DAY_W'(1);
            end else begin
              r_day <= DAY_W'(1);
              if (r_month >= DEC) begin
                r_month <= JAN;
                r_year  <= (r_year >= c_max_year) ? c_min_year : r_year + YEAR_W'(1);
              end else begin
                r_month <= r_month + MONTH_W'(1);
              end
            end
          end
        end
        // Outputs load on the way into APPLY so they are valid while in APPLY.
        CHECK: begin
          if (w_cap_ok) begin
            r_year  <= r_cap_year;
            r_month <= r_cap_month;
            r_day   <= r_cap_day;
`ifdef CAL_WEEKDAY_EN
            r_wday  <= r_cap_wday;
`endif
            r_upd   <= 1'b1;
            r_state <= APPLY;
          end else begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        APPLY: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cal_date_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cal_date_cnt : directed scoreboard bench for cal_date_cnt.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cal_date_cnt;

  logic        clk = 1'b0;
  logic        rst;
  logic        day_tick;
  logic        set_valid;
  logic        set_ready;
  logic [11:0] set_year;
  logic [3:0]  set_month;
  logic [4:0]  set_day;
  logic        set_err;
  logic [11:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic        date_upd;
`ifdef CAL_WEEKDAY_EN
  logic [2:0]  set_weekday = 3'd0;
  logic [2:0]  weekday;
`endif

  always #5 clk = ~clk;

  cal_date_cnt dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .day_tick_i    (day_tick),
    .set_valid_i   (set_valid),
    .set_ready_o   (set_ready),
    .set_year_i    (set_year),
    .set_month_i   (set_month),
    .set_day_i     (set_day),
    .set_err_o     (set_err),
    .year_o        (year),
    .month_o       (month),
    .day_o         (day),
`ifdef CAL_WEEKDAY_EN
    .set_weekday_i (set_weekday),
    .weekday_o     (weekday),
`endif
    .date_upd_o    (date_upd)
  );

  typedef struct {
    string       tag;
    logic [11:0] y;
    logic [3:0]  m;
    logic [4:0]  d;
    logic        upd;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] cy = 12'd2000;
  logic [3:0]  cm = 4'd1;
  logic [4:0]  cd = 5'd1;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input string tag, input logic upd, input logic err, input logic rdy);
    exp_t e;
    e.tag = tag; e.y = cy; e.m = cm; e.d = cd;
    e.upd = upd; e.err = err; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s.%s: got %0d expected %0d", tag, fld, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "year",  32'(year),      32'(e.y));
      cmp(e.tag, "month", 32'(month),     32'(e.m));
      cmp(e.tag, "day",   32'(day),       32'(e.d));
      cmp(e.tag, "upd",   32'(date_upd),  32'(e.upd));
      cmp(e.tag, "err",   32'(set_err),   32'(e.err));
      cmp(e.tag, "ready", 32'(set_ready), 32'(e.rdy));
    end
  endtask

  task automatic tick_step(input string tag, input int y, input int m, input int d);
    day_tick = 1'b1;
    cy = 12'(y); cm = 4'(m); cd = 5'(d);
    push_exp(tag, 1'b1, 1'b0, 1'b1);
    cyc();
    day_tick = 1'b0;
    check_out();
    push_exp({tag, "_hold"}, 1'b0, 1'b0, 1'b1);
    cyc();
    check_out();
  endtask

  task automatic write_step(input string tag, input int y, input int m, input int d, input bit ok);
    set_valid = 1'b1;
    set_year = 12'(y); set_month = 4'(m); set_day = 5'(d);
    push_exp({tag, "_chk"}, 1'b0, !ok, 1'b0);
    cyc();
    set_valid = 1'b0;
    check_out();
    if (ok) begin
      cy = 12'(y); cm = 4'(m); cd = 5'(d);
      push_exp({tag, "_apl"}, 1'b1, 1'b0, 1'b0);
      cyc();
      check_out();
    end
    push_exp({tag, "_idle"}, 1'b0, 1'b0, 1'b1);
    cyc();
    check_out();
  endtask

  initial begin
    rst = 1'b1; day_tick = 1'b0; set_valid = 1'b0;
    set_year = '0; set_month = '0; set_day = '0;
    @(negedge clk);
    cyc();
    push_exp("rst_hold", 1'b0, 1'b0, 1'b1);
    check_out();
    rst = 1'b0;
    push_exp("rst_rel", 1'b0, 1'b0, 1'b1);
    cyc();
    check_out();

    write_step("w_2023_01_31", 2023, 1, 31, 1'b1);
    tick_step("t_to_feb", 2023, 2, 1);
    write_step("w_2000_02_28", 2000, 2, 28, 1'b1);
    tick_step("t_leap400", 2000, 2, 29);
    write_step("w_2100_02_28", 2100, 2, 28, 1'b1);
    tick_step("t_noleap100", 2100, 3, 1);
    write_step("w_2024_02_29", 2024, 2, 29, 1'b1);
    tick_step("t_leap_end", 2024, 3, 1);
    write_step("w_2023_12_31", 2023, 12, 31, 1'b1);
    tick_step("t_newyear", 2024, 1, 1);
    write_step("w_2999_12_31", 2999, 12, 31, 1'b1);
    tick_step("t_wrap", 2000, 1, 1);

    write_step("rej_2023_02_29", 2023, 2, 29, 1'b0);
    write_step("w_2024_02_29b", 2024, 2, 29, 1'b1);
    write_step("rej_month0", 2024, 0, 5, 1'b0);
    write_step("rej_day0", 2024, 3, 0, 1'b0);
    write_step("rej_apr31", 2024, 4, 31, 1'b0);
    write_step("rej_month13", 2024, 13, 1, 1'b0);
    write_step("rej_1999", 1999, 1, 1, 1'b0);
    write_step("rej_3000", 3000, 1, 1, 1'b0);

    // Write and tick together; tick stays high through CHECK and APPLY.
    write_step("w_2023_05_10", 2023, 5, 10, 1'b1);
    day_tick = 1'b1; set_valid = 1'b1;
    set_year = 12'd2025; set_month = 4'd7; set_day = 5'd4;
    push_exp("sim_chk", 1'b0, 1'b0, 1'b0);
    cyc();
    set_valid = 1'b0;
    check_out();
    cy = 12'd2025; cm = 4'd7; cd = 5'd4;
    push_exp("sim_apl", 1'b1, 1'b0, 1'b0);
    cyc();
    day_tick = 1'b0;
    check_out();
    push_exp("sim_idle", 1'b0, 1'b0, 1'b1);
    cyc();
    check_out();
    push_exp("sim_quiet", 1'b0, 1'b0, 1'b1);
    cyc();
    check_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cal_date_cnt.md
Name: cal_date_cnt

Overview:
- Calendar date counter that owns the current year/month/day for the alarm-clock display path.
- Advances one day per day-rollover pulse from the time-of-day counter; accepts user date writes through a valid/ready handshake.
- year_o drives the year pixel renderer's year input directly; month_o/day_o feed the month and day renderers.
- Outputs are registered and only change on a committed update, so downstream digit lookups see stable values between updates.

Parameters:
- MIN_YEAR, 2000, lowest legal year; wrap target.
- MAX_YEAR, 2999, highest legal year; must be < 3000.
- RST_YEAR, 2000, year loaded on reset.
- RST_MONTH, 1, month loaded on reset (1..12).
- RST_DAY, 1, day loaded on reset (must be legal for RST_MONTH/RST_YEAR).
- YEAR_W, $clog2(3000), year field width (12).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- day_tick_i  in  1  single-cycle pulse at 23:59:59 -> 00:00:00.
- set_valid_i  in  1  user date write request.
- set_ready_o  out  1  high when a write can be accepted.
- set_year_i  in  YEAR_W  requested year.
- set_month_i  in  4  requested month, 1..12.
- set_day_i  in  5  requested day, 1..31.
- set_err_o  out  1  one-cycle pulse: write rejected.
- year_o  out  YEAR_W  current year.
- month_o  out  4  current month, 1..12.
- day_o  out  5  current day, 1..31.
- date_upd_o  out  1  one-cycle pulse on any change of the date outputs.

Behaviour:
- Clock: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset:
  - year_o/month_o/day_o = RST_YEAR/RST_MONTH/RST_DAY.
  - set_ready_o = 1; set_err_o = 0; date_upd_o = 0.
  - FSM returns to IDLE; a captured write is discarded.
- FSM states: IDLE, CHECK, APPLY.
  - IDLE: set_ready_o = 1. set_valid_i & set_ready_o captures the set_* fields -> CHECK.
  - CHECK: set_ready_o = 0. Validates the captured write:
    - year in [MIN_YEAR, MAX_YEAR];
    - month in 1..12;
    - day in 1..days_in_month(month, year).
    - Pass -> APPLY. Fail -> pulse set_err_o, outputs unchanged -> IDLE.
  - APPLY: set_ready_o = 0. Load the outputs and pulse date_upd_o -> IDLE.
  - Write latency: handshake in cycle N; outputs valid and date_upd_o high in cycle N+2; set_err_o high in cycle N+1.
- Day advance, IDLE only; day_tick_i in cycle N updates the outputs in N+1 with date_upd_o pulsed:
  - day < days_in_month: day+1.
  - Otherwise: day = 1 and month+1.
  - month 12 rollover: month = 1 and year+1.
  - year == MAX_YEAR rolling past Dec 31: year = MIN_YEAR.
- Leap year: divisible by 400, or divisible by 4 and not by 100.
  - February has 29 days if leap, else 28. Apr/Jun/Sep/Nov have 30 days; all other months have 31.
- Simultaneous events:
  - day_tick_i in the same cycle as an accepted write, or while in CHECK/APPLY: the tick is dropped; the user write wins.
  - A rejected write does not restore a tick dropped during CHECK.
- All arithmetic is unsigned. Validation compares at full input width, so set_day_i = 0 and set_month_i = 0 are rejected.

Optional Feature:
- Macro: CAL_WEEKDAY_EN.
- Defined:
  - Adds port weekday_o (out, 3 bits, 0 = Monday .. 6 = Sunday).
  - Adds port set_weekday_i (in, 3 bits).
  - Reset value is parameter RST_WEEKDAY (default 5, Saturday, matching 2000-01-01).
  - Increments mod 7 on every day advance.
  - Loaded from set_weekday_i in APPLY; set_weekday_i > 6 causes rejection in CHECK.
- Not defined: neither port exists; no weekday logic.

Decomposition:
- Package cal_pkg:
  - MONTH_W = 4, DAY_W = 5, YEAR_W.
  - Month constants JAN..DEC.
  - Functions is_leap(year) and days_in_month(month, year).
  - fsm_state_t enum {IDLE, CHECK, APPLY}.
- Sub-module cal_days_in_month: combinational; inputs month and year, output DAY_W-bit day count.
  - Instantiated twice: once for the current date, once for the captured write.

Test Plan:
- Reset -> 2000/1/1, set_ready_o = 1, no pulses.
- From 2023/1/31, pulse day_tick_i -> 2023/2/1 next cycle, date_upd_o = 1 for one cycle.
- 2000/2/28 tick -> 2000/2/29; 2100/2/28 tick -> 2100/3/1; 2024/2/29 tick -> 2024/3/1.
- 2999/12/31 tick -> 2000/1/1.
- Write 2023/2/29 -> set_err_o at N+1, outputs unchanged. Write 2024/2/29 -> outputs 2024/2/29 at N+2.
- Write accepted in the same cycle as day_tick_i (date 2023/5/10, write 2025/7/4) -> final date 2025/7/4; no extra advance.
